// File: rtl/brick_game_pkg.sv
// Shared types and helpers for the brick-breaker core: game states, ball direction, cell indexing.
package brick_game_pkg;

  localparam int SCORE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // dx=1 moves right, dy=1 moves down (towards the paddle row)
  typedef struct packed {
    logic dx;
    logic dy;
  } dir_t;

  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/brick_game_if.sv
// Player controls and display/score outputs of the brick-breaker core.
interface brick_game_if #(
  parameter int COLS       = 12,
  parameter int ROWS       = 16,
  parameter int BRICK_ROWS = 8
);
  import brick_game_pkg::*;

  logic                         tick;
  logic                         move_left;
  logic                         move_right;
  logic                         launch;
  logic [ROWS*COLS-1:0]         field;
  logic [BRICK_ROWS*COLS-1:0]   bricks;
  logic [$clog2(ROWS)-1:0]      ball_row;
  logic [$clog2(COLS)-1:0]      ball_col;
  logic [$clog2(COLS)-1:0]      paddle_pos;
  logic [SCORE_W-1:0]           score;
  logic [2:0]                   lives;
  logic [1:0]                   state;

  modport master (
    output tick, move_left, move_right, launch,
    input  field, bricks, ball_row, ball_col, paddle_pos, score, lives, state
  );

  modport slave (
    input  tick, move_left, move_right, launch,
    output field, bricks, ball_row, ball_col, paddle_pos, score, lives, state
  );

endinterface

// File: rtl/brick_collide.sv
// One ball step: wall reflection, then brick hit, paddle bounce or miss on the (reflected) target cell.
module brick_collide
  import brick_game_pkg::*;
#(
  parameter int COLS       = 12,
  parameter int ROWS       = 16,
  parameter int BRICK_ROWS = 8,
  parameter int PADDLE_W   = 3,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NB = BRICK_ROWS * COLS,
  localparam int IW = $clog2(NB)
) (
  input  logic [RW-1:0] ball_row,
  input  logic [CW-1:0] ball_col,
  input  dir_t          dir,
  input  logic [NB-1:0] bricks,
  input  logic [CW-1:0] paddle_pos,
  output logic [RW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output dir_t          nxt_dir,
  output logic [NB-1:0] nxt_bricks,
  output logic          brick_hit,
  output logic          miss
);

  int r, c, tr, tc, pp;
  logic [IW-1:0] hit_idx;

  always_comb begin
    r  = int'(ball_row);
    c  = int'(ball_col);
    pp = int'(paddle_pos);
    nxt_dir = dir;
    if (dir.dx ? (c == COLS - 1) : (c == 0)) nxt_dir.dx = ~dir.dx;
    if (!dir.dy && r == 0) nxt_dir.dy = 1'b1;
    tr = nxt_dir.dy ? r + 1 : r - 1;
    tc = nxt_dir.dx ? c + 1 : c - 1;
    hit_idx    = IW'(tr * COLS + tc);
    nxt_row    = ball_row;
    nxt_col    = ball_col;
    nxt_bricks = bricks;
    brick_hit  = 1'b0;
    miss       = 1'b0;
    if (tr < BRICK_ROWS && bricks[hit_idx]) begin
      // ball bounces off the brick without entering its cell
      brick_hit           = 1'b1;
      nxt_bricks[hit_idx] = 1'b0;
      nxt_dir.dy          = ~nxt_dir.dy;
    end else if (tr == ROWS - 1) begin
      if (tc >= pp && tc < pp + PADDLE_W) begin
        nxt_dir.dy = 1'b0;
        if (tc == pp) nxt_dir.dx = 1'b0;
        else if (tc == pp + PADDLE_W - 1) nxt_dir.dx = 1'b1;
      end else begin
        miss = 1'b1;
      end
    end else begin
      nxt_row = RW'(tr);
      nxt_col = CW'(tc);
    end
  end

endmodule

// File: rtl/brick_game_core.sv
// Brick-breaker engine: paddle, ball, wall, score, lives and IDLE/PLAY/WIN/OVER flow, one step per tick.
// Optional BRICK_GAME_SPEEDUP_EN: ball runs at half rate until the score reaches 16.
module brick_game_core
  import brick_game_pkg::*;
#(
  parameter int COLS       = 12,
  parameter int ROWS       = 16,
  parameter int BRICK_ROWS = 8,
  parameter int PADDLE_W   = 3,
  parameter int LIVES      = 3,
  parameter int SCORE_MAX  = 999
) (
  input logic clock,
  input logic reset,
  brick_game_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NB = BRICK_ROWS * COLS;
  localparam int NF = ROWS * COLS;
  localparam int FW = $clog2(NF);
  localparam logic [1:0]    S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0]    S_PLAY  = 2'(ST_PLAY);
  localparam logic [1:0]    S_WIN   = 2'(ST_WIN);
  localparam logic [1:0]    S_OVER  = 2'(ST_OVER);
  localparam logic [CW-1:0] PAD_RST = CW'((COLS - PADDLE_W) / 2);
  localparam logic [CW-1:0] PAD_MAX = CW'(COLS - PADDLE_W);
  localparam logic [CW-1:0] PAD_MID = CW'(PADDLE_W / 2);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s + 1'b1;
  endfunction

  logic [1:0]         state_q;
  logic [CW-1:0]      paddle_q, paddle_nxt, centre_col;
  logic [RW-1:0]      ball_row_q, c_row;
  logic [CW-1:0]      ball_col_q, c_col;
  dir_t               dir_q, c_dir;
  logic [NB-1:0]      bricks_q, c_bricks;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         lives_q;
  logic               c_hit, c_miss, step_en;
  logic [NF-1:0]      field_c;

  brick_collide #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_ROWS(BRICK_ROWS), .PADDLE_W(PADDLE_W)
  ) u_collide (
    .ball_row(ball_row_q), .ball_col(ball_col_q), .dir(dir_q), .bricks(bricks_q),
    .paddle_pos(paddle_q), .nxt_row(c_row), .nxt_col(c_col), .nxt_dir(c_dir),
    .nxt_bricks(c_bricks), .brick_hit(c_hit), .miss(c_miss)
  );

  always_comb begin
    paddle_nxt = paddle_q;
    if (bus.move_left && !bus.move_right && paddle_q != '0) paddle_nxt = paddle_q - 1'b1;
    else if (bus.move_right && !bus.move_left && paddle_q != PAD_MAX) paddle_nxt = paddle_q + 1'b1;
    centre_col = paddle_nxt + PAD_MID;
  end

`ifdef BRICK_GAME_SPEEDUP_EN
  logic phase_q;
  assign step_en = phase_q || (score_q >= SCORE_W'(16));
`else
  assign step_en = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      paddle_q   <= PAD_RST;
      ball_row_q <= RW'(ROWS - 2);
      ball_col_q <= PAD_RST + PAD_MID;
      dir_q      <= '{dx: 1'b1, dy: 1'b0};
      bricks_q   <= '1;
      score_q    <= '0;
      lives_q    <= 3'(LIVES);
`ifdef BRICK_GAME_SPEEDUP_EN
      phase_q    <= 1'b0;
`endif
    end else if (bus.tick) begin
      case (state_q)
        S_IDLE: begin
          paddle_q   <= paddle_nxt;
          ball_row_q <= RW'(ROWS - 2);
          ball_col_q <= centre_col;
          if (bus.launch) begin
            state_q <= S_PLAY;
            dir_q   <= '{dx: 1'b1, dy: 1'b0};
`ifdef BRICK_GAME_SPEEDUP_EN
            phase_q <= 1'b0;
`endif
          end
        end
        S_PLAY: begin
          paddle_q <= paddle_nxt;
`ifdef BRICK_GAME_SPEEDUP_EN
          phase_q  <= ~phase_q;
`endif
          if (step_en) begin
            dir_q <= c_dir;
            if (c_hit) begin
              bricks_q <= c_bricks;
              score_q  <= sat_inc(score_q);
              if (c_bricks == '0) state_q <= S_WIN;
            end else if (c_miss) begin
              lives_q <= lives_q - 1'b1;
              if (lives_q == 3'd1) begin
                state_q <= S_OVER;
              end else begin
                state_q    <= S_IDLE;
                ball_row_q <= RW'(ROWS - 2);
                ball_col_q <= centre_col;
              end
            end else begin
              ball_row_q <= c_row;
              ball_col_q <= c_col;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    field_c         = '0;
    field_c[NB-1:0] = bricks_q;
    for (int i = 0; i < PADDLE_W; i++)
      field_c[FW'(cell_idx(ROWS - 1, int'(paddle_q) + i, COLS))] = 1'b1;
    field_c[FW'(cell_idx(int'(ball_row_q), int'(ball_col_q), COLS))] = 1'b1;
  end

  assign bus.field      = field_c;
  assign bus.bricks     = bricks_q;
  assign bus.ball_row   = ball_row_q;
  assign bus.ball_col   = ball_col_q;
  assign bus.paddle_pos = paddle_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_brick_game_core.sv
// Bench for brick_game_core: game-rule model with ±1 velocities checked every cycle, plus hand-computed checkpoints.
module tb_brick_game_core;
  import brick_game_pkg::*;

  localparam int COLS = 12, ROWS = 16, BRICK_ROWS = 8, PW = 3, LIVES = 3, SCORE_MAX = 999;
  localparam int NB = BRICK_ROWS * COLS;
  localparam int NF = ROWS * COLS;
`ifdef BRICK_GAME_SPEEDUP_EN
  localparam int RATE = 2;
`else
  localparam int RATE = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  brick_game_if #(.COLS(COLS), .ROWS(ROWS), .BRICK_ROWS(BRICK_ROWS)) bus ();

  brick_game_core #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_ROWS(BRICK_ROWS), .PADDLE_W(PW),
    .LIVES(LIVES), .SCORE_MAX(SCORE_MAX)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_checks = 0, n_pass = 0;
  bit chk_en = 1'b0, brk_forced = 1'b0;

  bit m_brick [BRICK_ROWS][COLS];
  int m_pad, m_br, m_bc, m_dx, m_dy, m_score, m_lives, m_state, m_phase;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int r = 0; r < BRICK_ROWS; r++)
      for (int c = 0; c < COLS; c++) m_brick[r][c] = 1'b1;
    m_pad = (COLS - PW) / 2;
    m_br = ROWS - 2; m_bc = m_pad + PW / 2;
    m_dx = 1; m_dy = -1;
    m_score = 0; m_lives = LIVES; m_state = 0; m_phase = 0;
  endtask

  task automatic model_tick();
    int np, tr, tc, left;
    bit go;
    if (m_state >= 2) return;
    np = m_pad;
    if (bus.move_left && !bus.move_right) np = (m_pad > 0) ? m_pad - 1 : 0;
    else if (bus.move_right && !bus.move_left) np = (m_pad < COLS - PW) ? m_pad + 1 : COLS - PW;
    if (m_state == 0) begin
      m_br = ROWS - 2; m_bc = np + PW / 2;
      if (bus.launch) begin m_state = 1; m_dx = 1; m_dy = -1; m_phase = 0; end
      m_pad = np;
      return;
    end
    go = (RATE == 1) || (m_phase == 1) || (m_score >= 16);
    m_phase = 1 - m_phase;
    if (go) begin
      if (m_bc + m_dx < 0 || m_bc + m_dx >= COLS) m_dx = -m_dx;
      if (m_br + m_dy < 0) m_dy = -m_dy;
      tr = m_br + m_dy; tc = m_bc + m_dx;
      if (tr < BRICK_ROWS && m_brick[tr][tc]) begin
        m_brick[tr][tc] = 1'b0;
        m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
        m_dy = -m_dy;
        left = 0;
        for (int r = 0; r < BRICK_ROWS; r++)
          for (int c = 0; c < COLS; c++) left += int'(m_brick[r][c]);
        if (left == 0) m_state = 2;
      end else if (tr == ROWS - 1) begin
        if (tc >= m_pad && tc < m_pad + PW) begin
          m_dy = -1;
          if (tc == m_pad) m_dx = -1;
          else if (tc == m_pad + PW - 1) m_dx = 1;
        end else begin
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 0; m_br = ROWS - 2; m_bc = np + PW / 2; end
        end
      end else begin
        m_br = tr; m_bc = tc;
      end
    end
    m_pad = np;
  endtask

  always @(posedge clock) begin
    if (reset) model_reset();
    else if (bus.tick) model_tick();
  end

  always @(negedge clock) begin
    logic [NB-1:0] eb;
    logic [NF-1:0] ef;
    if (chk_en) begin
      check_int("state", int'(bus.state), m_state);
      check_int("score", int'(bus.score), m_score);
      check_int("lives", int'(bus.lives), m_lives);
      check_int("paddle_pos", int'(bus.paddle_pos), m_pad);
      check_int("ball_row", int'(bus.ball_row), m_br);
      check_int("ball_col", int'(bus.ball_col), m_bc);
      if (!brk_forced) begin
        eb = '0; ef = '0;
        for (int r = 0; r < BRICK_ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (m_brick[r][c]) begin eb[7'(r * COLS + c)] = 1'b1; ef[8'(r * COLS + c)] = 1'b1; end
        for (int i = 0; i < PW; i++) ef[8'((ROWS - 1) * COLS + m_pad + i)] = 1'b1;
        ef[8'(m_br * COLS + m_bc)] = 1'b1;
        check_vec("bricks", 256'(bus.bricks), 256'(eb));
        check_vec("field", 256'(bus.field), 256'(ef));
      end
    end
  end

  task automatic do_tick(input logic l, input logic r, input logic la);
    @(negedge clock);
    bus.move_left = l; bus.move_right = r; bus.launch = la; bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic run_until_lives(input int target);
    int n = 0;
    while (int'(bus.lives) != target && n < 400) begin do_tick(1'b0, 1'b1, 1'b0); n++; end
    check_int("lives_wait", int'(bus.lives), target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_pad [6] = '{3, 2, 1, 0, 0, 0};
    logic [NB-1:0] all_ones, one_brick;
    all_ones = '1;
    one_brick = '0;
    one_brick[7'(7 * COLS + 10)] = 1'b1;
    bus.tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.launch = 1'b0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    reset = 1'b0;

    // idle cycles with controls held but no tick: nothing may change
    bus.move_left = 1'b1; bus.launch = 1'b1;
    repeat (10) @(negedge clock);
    check_int("rst_state", int'(bus.state), 0);
    check_int("rst_score", int'(bus.score), 0);
    check_int("rst_lives", int'(bus.lives), 3);
    check_int("rst_paddle", int'(bus.paddle_pos), 4);
    check_int("rst_ball_row", int'(bus.ball_row), 14);
    check_int("rst_ball_col", int'(bus.ball_col), 5);
    check_vec("rst_bricks", 256'(bus.bricks), 256'(all_ones));

    for (int i = 0; i < 6; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      check_int("pad_left", int'(bus.paddle_pos), exp_pad[i]);
      check_int("ball_track", int'(bus.ball_col), exp_pad[i] + 1);
    end
    repeat (3) do_tick(1'b1, 1'b1, 1'b0);
    check_int("pad_both", int'(bus.paddle_pos), 0);
    repeat (12) do_tick(1'b0, 1'b1, 1'b0);
    check_int("pad_right_clamp", int'(bus.paddle_pos), 9);
    repeat (5) do_tick(1'b1, 1'b0, 1'b0);
    check_int("pad_back", int'(bus.paddle_pos), 4);

    // launch and fly up-right to the side wall, then into brick (7,10)
    do_tick(1'b0, 1'b0, 1'b1);
    check_int("launch_state", int'(bus.state), 1);
    check_int("launch_row", int'(bus.ball_row), 14);
    do_tick(1'b0, 1'b0, 1'b0);
    check_int("first_step_row", int'(bus.ball_row), (RATE == 1) ? 13 : 14);
    repeat (7 * RATE - 1) do_tick(1'b0, 1'b0, 1'b0);
    check_int("hit_score", int'(bus.score), 1);
    check_int("hit_row", int'(bus.ball_row), 8);
    check_int("hit_col", int'(bus.ball_col), 11);
    check_int("hit_brick_gone", int'(bus.bricks[7'(7 * COLS + 10)]), 0);
    repeat (RATE) do_tick(1'b0, 1'b1, 1'b0);
    check_int("down_row", int'(bus.ball_row), 9);
    check_int("down_col", int'(bus.ball_col), 10);

    // paddle parked at the right edge: three misses end the game
    run_until_lives(2);
    check_int("miss1_state", int'(bus.state), 0);
    check_int("miss1_row", int'(bus.ball_row), 14);
    check_int("miss1_col", int'(bus.ball_col), 10);
    do_tick(1'b0, 1'b1, 1'b1);
    run_until_lives(1);
    do_tick(1'b0, 1'b1, 1'b1);
    run_until_lives(0);
    check_int("over_state", int'(bus.state), 3);
    repeat (4) do_tick(1'b1, 1'b0, 1'b1);
    check_int("over_frozen", int'(bus.state), 3);
    check_int("over_pad", int'(bus.paddle_pos), 9);

    // reset in the middle of a game, with no tick
    apply_reset();
    do_tick(1'b0, 1'b0, 1'b1);
    repeat (7 * RATE) do_tick(1'b0, 1'b0, 1'b0);
    check_int("pre_reset_score", int'(bus.score), 1);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check_int("mid_rst_state", int'(bus.state), 0);
    check_int("mid_rst_score", int'(bus.score), 0);
    check_int("mid_rst_row", int'(bus.ball_row), 14);
    check_vec("mid_rst_bricks", 256'(bus.bricks), 256'(all_ones));

    // single remaining brick: clearing it wins on the same tick
    @(negedge clock);
    force dut.bricks_q = one_brick;
    brk_forced = 1'b1;
    for (int r = 0; r < BRICK_ROWS; r++)
      for (int c = 0; c < COLS; c++) m_brick[r][c] = (r == 7 && c == 10);
    do_tick(1'b0, 1'b0, 1'b1);
    repeat (7 * RATE) do_tick(1'b0, 1'b0, 1'b0);
    check_int("win_state", int'(bus.state), 2);
    check_int("win_score", int'(bus.score), 1);
    repeat (3) do_tick(1'b1, 1'b0, 1'b1);
    check_int("win_frozen", int'(bus.state), 2);
    check_int("win_row", int'(bus.ball_row), 8);
    check_int("win_col", int'(bus.ball_col), 11);
    check_int("win_pad", int'(bus.paddle_pos), 4);
    @(negedge clock);
    release dut.bricks_q;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    brk_forced = 1'b0;
    check_vec("final_bricks", 256'(bus.bricks), 256'(all_ones));
    check_int("final_state", int'(bus.state), 0);
    repeat (2) @(negedge clock);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
